// File: rtl/t1_bank_1rw_resp_if.sv
// t1_bank_1rw_resp_if: per-bank command/response bundle between the memory top (master) and the bank model (slave)
interface t1_bank_1rw_resp_if #(
  parameter int NUMPBNK = 11,
  parameter int BITSROW = 8,
  parameter int PHYWDTH = 128
);
  logic [NUMPBNK-1:0]         t1_readA;
  logic [NUMPBNK-1:0]         t1_writeA;
  logic [NUMPBNK*BITSROW-1:0] t1_addrA;
  logic [NUMPBNK*PHYWDTH-1:0] t1_bwA;
  logic [NUMPBNK*PHYWDTH-1:0] t1_dinA;
  logic [NUMPBNK*PHYWDTH-1:0] t1_doutA;
  logic                       init_done;
  logic [NUMPBNK-1:0]         err_coll;
  logic [NUMPBNK-1:0]         err_addr;
  modport master (
    output t1_readA, t1_writeA, t1_addrA, t1_bwA, t1_dinA,
    input  t1_doutA, init_done, err_coll, err_addr
  );
  modport slave (
    input  t1_readA, t1_writeA, t1_addrA, t1_bwA, t1_dinA,
    output t1_doutA, init_done, err_coll, err_addr
  );
endinterface

// File: rtl/t1_bank_1rw_resp.sv
// t1_bank_1rw_resp: NUMPBNK independent 1RW banks with init sweep, bit-masked writes and SRAM_DELAY read latency
module t1_bank_1rw_resp #(
  parameter int                   NUMPBNK    = 11,
  parameter int                   NUMSROW    = 256,
  parameter int                   BITSROW    = 8,
  parameter int                   PHYWDTH    = 128,
  parameter int                   SRAM_DELAY = 2,
  parameter logic [PHYWDTH-1:0]   INITVAL    = '0
) (
  input logic               clk,
  input logic               rst,
  t1_bank_1rw_resp_if.slave t1
);
  typedef enum logic {INIT, DONE} state_t;
  state_t               state_q;
  logic [BITSROW-1:0]   init_cnt_q;
  logic [PHYWDTH-1:0]   mem [NUMPBNK][NUMSROW];
  logic [SRAM_DELAY-1:0] vld_q [NUMPBNK];
  logic [PHYWDTH-1:0]   dat_q [NUMPBNK][SRAM_DELAY];
  logic [PHYWDTH-1:0]   hold_q [NUMPBNK];
  logic [NUMPBNK-1:0]   err_coll_q, err_addr_q;
  logic [BITSROW-1:0]   addr [NUMPBNK];
  logic [PHYWDTH-1:0]   bw [NUMPBNK];
  logic [PHYWDTH-1:0]   din [NUMPBNK];
  logic [PHYWDTH-1:0]   rd_dat [NUMPBNK];
  logic [PHYWDTH-1:0]   dout [NUMPBNK];
  logic [NUMPBNK-1:0]   rd, wr, ok;
  always_comb begin
    for (int b = 0; b < NUMPBNK; b++) begin
      addr[b]   = t1.t1_addrA[b*BITSROW +: BITSROW];
      bw[b]     = t1.t1_bwA[b*PHYWDTH +: PHYWDTH];
      din[b]    = t1.t1_dinA[b*PHYWDTH +: PHYWDTH];
      ok[b]     = 32'(addr[b]) < 32'(NUMSROW);
      rd[b]     = (state_q == DONE) && t1.t1_readA[b];
      wr[b]     = (state_q == DONE) && t1.t1_writeA[b];
      // colliding or out-of-range reads still occupy the pipeline but return zero
      rd_dat[b] = (rd[b] && !wr[b] && ok[b]) ? mem[b][addr[b]] : '0;
      dout[b]   = vld_q[b][SRAM_DELAY-1] ? dat_q[b][SRAM_DELAY-1] : hold_q[b];
    end
  end
  always_comb begin
    t1.t1_doutA = '0;
    for (int b = 0; b < NUMPBNK; b++) t1.t1_doutA[b*PHYWDTH +: PHYWDTH] = dout[b];
  end
  assign t1.init_done = state_q == DONE;
  assign t1.err_coll  = err_coll_q;
  assign t1.err_addr  = err_addr_q;
  // array has no reset; the init sweep is what clears it
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUMPBNK; b++) begin
      if (state_q == INIT) mem[b][init_cnt_q] <= INITVAL;
      else if (wr[b] && ok[b]) mem[b][addr[b]] <= (mem[b][addr[b]] & ~bw[b]) | (din[b] & bw[b]);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      err_coll_q <= '0;
      err_addr_q <= '0;
      for (int b = 0; b < NUMPBNK; b++) begin
        vld_q[b]  <= '0;
        hold_q[b] <= '0;
        for (int k = 0; k < SRAM_DELAY; k++) dat_q[b][k] <= '0;
      end
    end else begin
      if (state_q == INIT) begin
        init_cnt_q <= init_cnt_q + 1'b1;
        if (init_cnt_q == BITSROW'(NUMSROW-1)) state_q <= DONE;
      end
      err_coll_q <= rd & wr;
      err_addr_q <= (rd | wr) & ~ok;
      for (int b = 0; b < NUMPBNK; b++) begin
        vld_q[b]    <= (vld_q[b] << 1) | SRAM_DELAY'(rd[b]);
        dat_q[b][0] <= rd_dat[b];
        for (int k = 1; k < SRAM_DELAY; k++) dat_q[b][k] <= dat_q[b][k-1];
        hold_q[b]   <= dout[b];
      end
    end
  end
endmodule

// File: tb/tb_t1_bank_1rw_resp.sv
// tb_t1_bank_1rw_resp: directed checks of init sweep, masked writes, latency, collisions and reset of the bank model
module tb_t1_bank_1rw_resp;
  localparam int NB = 11, NR = 256, BR = 8, W = 128;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0, bad = 0;
  t1_bank_1rw_resp_if #(.NUMPBNK(NB), .BITSROW(BR), .PHYWDTH(W)) bus ();
  t1_bank_1rw_resp #(.NUMPBNK(NB), .NUMSROW(NR), .BITSROW(BR), .PHYWDTH(W),
                     .SRAM_DELAY(2), .INITVAL('0)) dut (.clk(clk), .rst(rst), .t1(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.t1_readA  = '0;
    bus.t1_writeA = '0;
    bus.t1_addrA  = '0;
    bus.t1_bwA    = '0;
    bus.t1_dinA   = '0;
  endtask
  task automatic cmd(int b, bit r, bit w, logic [7:0] row, logic [W-1:0] d, logic [W-1:0] m);
    bus.t1_readA[b]             = r;
    bus.t1_writeA[b]            = w;
    bus.t1_addrA[b*BR +: BR]    = row;
    bus.t1_dinA[b*W +: W]       = d;
    bus.t1_bwA[b*W +: W]        = m;
  endtask
  function automatic logic [W-1:0] lane(int b);
    return bus.t1_doutA[b*W +: W];
  endfunction
  function automatic logic [W-1:0] pat(int b, int r);
    logic [7:0] bb, rr;
    bb = 8'(b);
    rr = 8'(r);
    return {8{bb, rr}};
  endfunction
  task automatic wr1(int b, logic [7:0] row, logic [W-1:0] d, logic [W-1:0] m);
    cmd(b, 1'b0, 1'b1, row, d, m);
    tick();
    idle();
  endtask
  task automatic rd1(string tag, int b, logic [7:0] row, logic [W-1:0] exp);
    cmd(b, 1'b1, 1'b0, row, '0, '0);
    tick();
    idle();
    tick();
    chk(tag, lane(b), exp);
  endtask
  localparam logic [W-1:0] ONES = '1;
  initial begin
    idle();
    repeat (3) tick();
    chk("rst_dout", bus.t1_doutA[W-1:0], '0);
    chk("rst_done", W'(bus.init_done), '0);
    chk("rst_err", W'({bus.err_coll, bus.err_addr}), '0);
    rst = 1'b1;
    for (int i = 1; i <= NR; i++) begin
      if (i == 10) cmd(1, 1'b1, 1'b1, 8'h00, ONES, ONES);
      tick();
      idle();
      if (i == 10) chk("init_ign_err", W'({bus.err_coll, bus.err_addr}), '0);
      if (i == 12) chk("init_ign_dout", lane(1), '0);
      if (i == NR-1) chk("init_low", W'(bus.init_done), '0);
      if (i == NR) chk("init_high", W'(bus.init_done), 1);
    end
    rd1("init_b3_r10", 3, 8'h10, '0);
    rd1("init_ign_mem", 1, 8'h00, '0);
    wr1(0, 8'd5, {16{8'hA5}}, ONES);
    cmd(0, 1'b1, 1'b0, 8'd5, '0, '0);
    tick();
    idle();
    chk("lat_early", lane(0), '0);
    tick();
    chk("raw_a5", lane(0), {16{8'hA5}});
    chk("other_lane1", lane(1), '0);
    wr1(0, 8'd7, ONES, ONES);
    wr1(0, 8'd7, '0, W'(16'h00FF));
    rd1("mask_lowbyte", 0, 8'd7, {{(W-8){1'b1}}, 8'h00});
    wr1(0, 8'd7, '0, '0);
    rd1("mask_zero", 0, 8'd7, {{(W-8){1'b1}}, 8'h00});
    chk("hold_lane0", lane(0), {{(W-8){1'b1}}, 8'h00});
    wr1(2, 8'd9, W'(16'hBEEF), ONES);
    rd1("b2_preload", 2, 8'd9, W'(16'hBEEF));
    cmd(2, 1'b1, 1'b1, 8'd1, W'(16'h1234), ONES);
    tick();
    idle();
    chk("coll_err", W'(bus.err_coll), W'(11'b000_0000_0100));
    tick();
    chk("coll_pulse", W'(bus.err_coll), '0);
    chk("coll_dout", lane(2), '0);
    rd1("coll_wr_done", 2, 8'd1, W'(16'h1234));
    for (int r = 32; r < 64; r++) begin
      for (int b = 0; b < NB; b++) cmd(b, 1'b0, 1'b1, 8'(r), pat(b, r), ONES);
      tick();
    end
    idle();
    for (int i = 0; i <= 20; i++) begin
      idle();
      if (i < 20) for (int b = 0; b < NB; b++) cmd(b, 1'b1, 1'b0, 8'(32 + i + b), '0, '0);
      tick();
      if (i >= 1) for (int b = 0; b < NB; b++) chk($sformatf("stream_i%0d_b%0d", i-1, b), lane(b), pat(b, 32 + i - 1 + b));
    end
    idle();
    tick();
    cmd(0, 1'b1, 1'b0, 8'd5, '0, '0);
    tick();
    cmd(0, 1'b1, 1'b0, 8'd32, '0, '0);
    tick();
    idle();
    chk("pre_rst_lane0", lane(0), {16{8'hA5}});
    rst = 1'b0;
    #1;
    chk("rst_mid_dout", lane(0), '0);
    chk("rst_mid_done", W'(bus.init_done), '0);
    tick();
    rst = 1'b1;
    for (int i = 1; i <= NR; i++) begin
      tick();
      if (i == NR-1) chk("reinit_low", W'(bus.init_done), '0);
    end
    chk("reinit_high", W'(bus.init_done), 1);
    chk("reinit_dout", lane(0), '0);
    rd1("reinit_b0_r5", 0, 8'd5, '0);
    rd1("reinit_b5_r40", 5, 8'd40, '0);
    rd1("reinit_b2_r1", 2, 8'd1, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
